unsigned_approx_dot_acc: RTL and testbench
==========================================

// Module: unsigned_approx_dot_acc
// PURPOSE
//  Downstream consumer of the unsigned 8x8 approximate multipliers. Accepts a
//  stream of 16-bit products over a valid/ready handshake and accumulates a
//  dot product of programmable length. Presents the sum on a held
//  valid/ready output. Sits between the combinational multiplier array and
//  the result/statistics collector of the approximate-MAC datapath.
// PARAMETERS
//  ACC_W  24  accumulator width in bits; must be >= 16
//  LEN_W   8  width of the vector-length field; max length 2**LEN_W-1
// PORTS
//  clk        in   1       single clock; all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       one-cycle request to begin a vector; sampled in IDLE only
//  len        in   LEN_W   number of products in the vector; sampled with start
//  p_valid    in   1       product beat valid
//  p_ready    out  1       block can accept a product beat
//  p          in   16      product z from the approximate multiplier
//  acc_valid  out  1       accumulated result valid
//  acc_ready  in   1       downstream accepts result
//  acc        out  ACC_W   accumulated sum
//  acc_ovf    out  1       sticky: carry out of ACC_W occurred during this vector
//  busy       out  1       high in RUN or DONE
// BEHAVIOUR
//  - Reset: state=IDLE. p_ready, acc_valid, acc_ovf and busy are 0. acc=0. Count=0.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE -> RUN when start=1 and len!=0. Latch len, clear acc, acc_ovf and count.
//  - IDLE -> DONE when start=1 and len==0. acc=0, acc_ovf=0.
//  - start in RUN or DONE is ignored. len is ignored unless start=1 in IDLE.
//  - RUN: p_ready=1 combinationally. A beat transfers when p_valid & p_ready.
//    On a beat, acc <= acc + zero_ext(p) modulo 2**ACC_W, and count <= count+1.
//    On carry out of bit ACC_W-1, acc_ovf is set and stays set for the vector.
//  - RUN -> DONE on the beat where count==len-1. That final beat is accumulated.
//    acc_valid=1 in the cycle after the final beat (1-cycle latency).
//    p_ready=0 in that same cycle.
//  - Gaps (p_valid=0) in RUN stall the count. There is no timeout.
//  - DONE: acc_valid=1; acc and acc_ovf are held stable. p_ready=0.
//    DONE -> IDLE on acc_valid & acc_ready. acc keeps its value in IDLE until
//    the next start.
//  - acc_ready may be high before acc_valid; the transfer completes in the
//    first DONE cycle.
//  - rst=1 in any state, including mid-vector: return to the reset values next
//    edge. Partial sums are discarded.
//  - p is treated as unsigned. No rounding or saturation; wrap plus sticky
//    flag only.
// CONFIGURATION
//  ERR_STAT_EN defined: extra ports
//    p_exact  in   16      exact product for the same beat; sampled with p
//    err_sum  out  ACC_W   sum of |p_exact - p| over the vector (wraps)
//    err_max  out  16      max |p_exact - p| over the vector
//  Both error outputs clear on vector start or rst, update on each beat, and
//  are held in DONE alongside acc.
//  ERR_STAT_EN undefined: these ports and their logic are absent. The core
//  behaviour is identical in both builds.
// TESTING
//  1 rst; start, len=3; beats p=100,200,300 back-to-back -> acc_valid 1 cycle
//    after beat 3, acc=600, acc_ovf=0.
//  2 len=4 with p_valid gaps of 2 cycles between beats of p=65535 each ->
//    acc=262140; p_ready=0 in DONE.
//  3 ACC_W=16, len=2, p=65535,2 -> acc=1, acc_ovf=1. Next vector len=1, p=5 ->
//    acc=5, acc_ovf=0.
//  4 start, len=0 -> DONE next cycle, acc=0. acc_ready held low 5 cycles ->
//    acc_valid and acc stable; release -> IDLE.
//  5 rst asserted after 2 of 5 beats -> busy=0, acc=0, p_ready=0 next cycle.
//    A start pulse during RUN does not restart the count.
//  6 ERR_STAT_EN: beats (p,p_exact)=(96,100),(210,200) -> err_sum=14, err_max=10.

Source files
------------

// File: rtl/unsigned_approx_dot_acc.sv
// ---------------------------------------------------------------------------
// unsigned_approx_dot_acc
//
// Accumulates a dot product of programmable length from a stream of 16-bit
// unsigned products delivered by the approximate-multiplier array. The
// finished sum is held on a valid/ready output until the downstream result
// collector accepts it.
//
// Optional build macro: ERR_STAT_EN
//   When defined, the block also accepts the exact product alongside each beat
//   and reports the running sum and maximum of |p_exact - p| for the vector.
//   When undefined, those ports and their logic are absent.
//
// Ports
//   clk        in   1      clock, all state changes on the rising edge
//   rst        in   1      synchronous active-high reset
//   start      in   1      begin a vector (only honoured in IDLE)
//   len        in   LEN_W  vector length, sampled with start
//   p_valid    in   1      product beat valid
//   p_ready    out  1      block accepts a product beat (RUN only)
//   p          in   16     approximate product
//   acc_valid  out  1      accumulated result valid (DONE)
//   acc_ready  in   1      downstream accepts the result
//   acc        out  ACC_W  accumulated sum (wraps modulo 2**ACC_W)
//   acc_ovf    out  1      sticky carry-out seen during this vector
//   busy       out  1      high in RUN or DONE
//   p_exact    in   16     exact product for the beat      (ERR_STAT_EN)
//   err_sum    out  ACC_W  sum of |p_exact - p| (wraps)     (ERR_STAT_EN)
//   err_max    out  16     max of |p_exact - p|             (ERR_STAT_EN)
// ---------------------------------------------------------------------------
module unsigned_approx_dot_acc #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [15:0]      p,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc,
  output logic             acc_ovf,
  output logic             busy
`ifdef ERR_STAT_EN
  ,
  input  logic [15:0]      p_exact,
  output logic [ACC_W-1:0] err_sum,
  output logic [15:0]      err_max
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   len_q;
  logic               beat_s;
  logic               last_s;
  logic               vec_start_s;
  logic [ACC_W:0]     sum_s;

  // A vector starts only from IDLE; start in any other state is ignored.
  assign vec_start_s = (state_q == S_IDLE) && start;
  assign beat_s      = (state_q == S_RUN) && p_valid;
  // len_q is never zero while in RUN, so len_q-1 cannot underflow here.
  assign last_s      = beat_s && (cnt_q == (len_q - LEN_W'(1)));
  // One extra bit captures the carry out of the accumulator.
  assign sum_s       = {1'b0, acc_q} + (ACC_W + 1)'(p);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len != LEN_W'(0)) ? S_RUN : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (acc_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, purely from the state register.
  always_comb begin
    p_ready   = 1'b0;
    acc_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        p_ready   = 1'b0;
        acc_valid = 1'b0;
        busy      = 1'b0;
      end
      S_RUN: begin
        p_ready   = 1'b1;
        acc_valid = 1'b0;
        busy      = 1'b1;
      end
      S_DONE: begin
        p_ready   = 1'b0;
        acc_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        p_ready   = 1'b0;
        acc_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Accumulator, sticky overflow, beat counter and latched length.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      len_q <= '0;
    end else if (vec_start_s) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      len_q <= len;
    end else if (beat_s) begin
      acc_q <= sum_s[ACC_W-1:0];
      ovf_q <= ovf_q | sum_s[ACC_W];
      cnt_q <= cnt_q + LEN_W'(1);
    end else begin
      acc_q <= acc_q;
      ovf_q <= ovf_q;
      cnt_q <= cnt_q;
      len_q <= len_q;
    end
  end

  assign acc     = acc_q;
  assign acc_ovf = ovf_q;

`ifdef ERR_STAT_EN
  logic [ACC_W-1:0] esum_q;
  logic [15:0]      emax_q;
  logic [15:0]      diff_s;

  assign diff_s = (p_exact >= p) ? (p_exact - p) : (p - p_exact);

  // Error statistics follow the same clear/update timing as the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      esum_q <= '0;
      emax_q <= 16'd0;
    end else if (vec_start_s) begin
      esum_q <= '0;
      emax_q <= 16'd0;
    end else if (beat_s) begin
      esum_q <= esum_q + ACC_W'(diff_s);
      emax_q <= (diff_s > emax_q) ? diff_s : emax_q;
    end else begin
      esum_q <= esum_q;
      emax_q <= emax_q;
    end
  end

  assign err_sum = esum_q;
  assign err_max = emax_q;
`endif

endmodule

// File: tb/tb_unsigned_approx_dot_acc.sv
// ---------------------------------------------------------------------------
// Bench for unsigned_approx_dot_acc. Two instances share every input: one with
// ACC_W=24 and one with ACC_W=16 so wrap/sticky-overflow behaviour is visible.
// Vectors come from a table; the expected result of each vector is pushed to a
// per-instance queue when its last beat is driven and popped by a monitor when
// the result handshake completes.
// ---------------------------------------------------------------------------
module tb_unsigned_approx_dot_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        p_valid;
  logic [15:0] p;
  logic [15:0] p_exact;
  logic        acc_ready;

  logic        p_ready24, acc_valid24, acc_ovf24, busy24;
  logic [23:0] acc24;
  logic        p_ready16, acc_valid16, acc_ovf16, busy16;
  logic [15:0] acc16;
`ifdef ERR_STAT_EN
  logic [23:0] err_sum24;
  logic [15:0] err_max24;
  logic [15:0] err_sum16;
  logic [15:0] err_max16;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [23:0] acc;
    logic        ovf;
    logic [23:0] esum;
    logic [15:0] emax;
  } exp_t;

  exp_t q24[$];
  exp_t q16[$];

  typedef struct {
    int          n;
    logic [15:0] pv[4];
    logic [15:0] pe[4];
    int          gap;
    int          rdly;
    int          spulse;
    logic [23:0] a24;
    logic        o24;
    logic [15:0] a16;
    logic        o16;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  unsigned_approx_dot_acc #(.ACC_W(24), .LEN_W(8)) dut24 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .p_valid(p_valid), .p_ready(p_ready24), .p(p),
    .acc_valid(acc_valid24), .acc_ready(acc_ready),
    .acc(acc24), .acc_ovf(acc_ovf24), .busy(busy24)
`ifdef ERR_STAT_EN
    , .p_exact(p_exact), .err_sum(err_sum24), .err_max(err_max24)
`endif
  );

  unsigned_approx_dot_acc #(.ACC_W(16), .LEN_W(8)) dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .p_valid(p_valid), .p_ready(p_ready16), .p(p),
    .acc_valid(acc_valid16), .acc_ready(acc_ready),
    .acc(acc16), .acc_ovf(acc_ovf16), .busy(busy16)
`ifdef ERR_STAT_EN
    , .p_exact(p_exact), .err_sum(err_sum16), .err_max(err_max16)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: a result transfers on the next rising edge when
  // valid and ready are both high at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && acc_valid24 && acc_ready) begin
      if (q24.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb24_unexpected: got result %0d expected none", acc24);
      end else begin
        e = q24.pop_front();
        chk("sb24_acc", 32'(acc24), 32'(e.acc));
        chk("sb24_ovf", 32'(acc_ovf24), 32'(e.ovf));
`ifdef ERR_STAT_EN
        chk("sb24_err_sum", 32'(err_sum24), 32'(e.esum));
        chk("sb24_err_max", 32'(err_max24), 32'(e.emax));
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && acc_valid16 && acc_ready) begin
      if (q16.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb16_unexpected: got result %0d expected none", acc16);
      end else begin
        e = q16.pop_front();
        chk("sb16_acc", 32'(acc16), 32'(e.acc));
        chk("sb16_ovf", 32'(acc_ovf16), 32'(e.ovf));
`ifdef ERR_STAT_EN
        chk("sb16_err_sum", 32'(err_sum16), 32'(e.esum));
        chk("sb16_err_max", 32'(err_max16), 32'(e.emax));
`endif
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int   esum;
    int   emax;
    int   diff;
    exp_t e24;
    exp_t e16;
    esum = 0;
    emax = 0;
    e24.acc = v.a24; e24.ovf = v.o24;
    e16.acc = 24'(v.a16); e16.ovf = v.o16;
    acc_ready = (v.rdly == 0) ? 1'b1 : 1'b0;
    if (v.n == 0) begin
      e24.esum = 24'd0; e24.emax = 16'd0;
      e16.esum = 24'd0; e16.emax = 16'd0;
      q24.push_back(e24);
      q16.push_back(e16);
    end
    start = 1'b1;
    len   = 8'(v.n);
    cyc();
    start = 1'b0;
    len   = 8'($urandom);
    chk("busy_after_start", 32'(busy24), 32'd1);
    for (int i = 0; i < v.n; i++) begin
      for (int g = 0; g < v.gap; g++) begin
        p_valid = 1'b0;
        cyc();
      end
      chk("p_ready_run", 32'(p_ready24), 32'd1);
      chk("acc_valid_run", 32'(acc_valid24), 32'd0);
      p_valid = 1'b1;
      p       = v.pv[i];
      p_exact = v.pe[i];
      if (i == v.spulse) begin
        start = 1'b1;
        len   = 8'd255;
      end
      diff = (p_exact >= p) ? int'(p_exact - p) : int'(p - p_exact);
      esum = esum + diff;
      if (diff > emax) emax = diff;
      if (i == v.n - 1) begin
        e24.esum = 24'(esum); e24.emax = 16'(emax);
        e16.esum = 24'(16'(esum)); e16.emax = 16'(emax);
        q24.push_back(e24);
        q16.push_back(e16);
      end
      cyc();
      start = 1'b0;
    end
    p_valid = 1'b0;
    // One cycle after the final beat the result must be presented.
    chk("acc_valid_done", 32'(acc_valid24), 32'd1);
    chk("p_ready_done24", 32'(p_ready24), 32'd0);
    chk("p_ready_done16", 32'(p_ready16), 32'd0);
    for (int k = 0; k < v.rdly; k++) begin
      cyc();
      chk("hold_valid", 32'(acc_valid24), 32'd1);
      chk("hold_acc24", 32'(acc24), 32'(v.a24));
      chk("hold_acc16", 32'(acc16), 32'(v.a16));
    end
    acc_ready = 1'b1;
    cyc();
    acc_ready = 1'b0;
    chk("idle_busy", 32'(busy24), 32'd0);
    chk("idle_valid", 32'(acc_valid16), 32'd0);
  endtask

  initial begin
    tbl[0] = '{3, '{16'd100, 16'd200, 16'd300, 16'd0}, '{16'd100, 16'd200, 16'd300, 16'd0},
               0, 0, -1, 24'd600, 1'b0, 16'd600, 1'b0};
    tbl[1] = '{4, '{16'd65535, 16'd65535, 16'd65535, 16'd65535}, '{16'd65535, 16'd65535, 16'd65535, 16'd65535},
               2, 0, -1, 24'd262140, 1'b0, 16'd65532, 1'b1};
    tbl[2] = '{2, '{16'd65535, 16'd2, 16'd0, 16'd0}, '{16'd65535, 16'd2, 16'd0, 16'd0},
               0, 0, -1, 24'd65537, 1'b0, 16'd1, 1'b1};
    tbl[3] = '{1, '{16'd5, 16'd0, 16'd0, 16'd0}, '{16'd5, 16'd0, 16'd0, 16'd0},
               0, 2, -1, 24'd5, 1'b0, 16'd5, 1'b0};
    tbl[4] = '{0, '{16'd0, 16'd0, 16'd0, 16'd0}, '{16'd0, 16'd0, 16'd0, 16'd0},
               0, 5, -1, 24'd0, 1'b0, 16'd0, 1'b0};
    tbl[5] = '{2, '{16'd96, 16'd210, 16'd0, 16'd0}, '{16'd100, 16'd200, 16'd0, 16'd0},
               1, 0, -1, 24'd306, 1'b0, 16'd306, 1'b0};
    tbl[6] = '{3, '{16'd1, 16'd2, 16'd3, 16'd0}, '{16'd1, 16'd2, 16'd3, 16'd0},
               0, 0, 1, 24'd6, 1'b0, 16'd6, 1'b0};
    tbl[7] = '{4, '{16'd60000, 16'd60000, 16'd60000, 16'd60000}, '{16'd60000, 16'd60000, 16'd60000, 16'd60000},
               1, 1, -1, 24'd240000, 1'b0, 16'd43392, 1'b1};

    rst = 1'b1; start = 1'b0; len = 8'd0; p_valid = 1'b0;
    p = 16'd0; p_exact = 16'd0; acc_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_busy", 32'(busy24), 32'd0);
    chk("rst_p_ready", 32'(p_ready24), 32'd0);
    chk("rst_acc_valid", 32'(acc_valid24), 32'd0);
    chk("rst_acc", 32'(acc24), 32'd0);
    chk("rst_ovf", 32'(acc_ovf24), 32'd0);
    rst = 1'b0;
    cyc();

    for (int t = 0; t < 8; t++) begin
      run_vec(tbl[t]);
    end

    // Reset in the middle of a 5-beat vector discards the partial sum.
    start = 1'b1; len = 8'd5;
    cyc();
    start = 1'b0;
    p_valid = 1'b1; p = 16'd10; p_exact = 16'd10;
    cyc();
    p = 16'd20;
    cyc();
    p_valid = 1'b0;
    chk("partial_acc", 32'(acc24), 32'd30);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy24), 32'd0);
    chk("midrst_acc", 32'(acc24), 32'd0);
    chk("midrst_p_ready", 32'(p_ready24), 32'd0);
    chk("midrst_acc_valid", 32'(acc_valid24), 32'd0);
    cyc();

    // Block recovers normally after the abort.
    run_vec(tbl[0]);
    repeat (3) cyc();

    chk("sb24_drained", 32'(q24.size()), 32'd0);
    chk("sb16_drained", 32'(q16.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
